// File: rtl/ahb_bus_arbiter_if.sv
// rtl/ahb_bus_arbiter_if.sv - two-master AHB-Lite arbiter bus bundle
interface ahb_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  HBUSREQ0, HBUSREQ1;
    logic                  HLOCK0, HLOCK1;
    logic [ADDR_WIDTH-1:0] HADDR0, HADDR1;
    logic [1:0]            HTRANS0, HTRANS1;
    logic                  HWRITE0, HWRITE1;
    logic [2:0]            HSIZE0, HSIZE1;
    logic [2:0]            HBURST0, HBURST1;
    logic [3:0]            HPROT0, HPROT1;
    logic [DATA_WIDTH-1:0] HWDATA0, HWDATA1;
    logic                  HREADY;

    logic                  HGRANT0, HGRANT1;
    logic                  HMASTER;
    logic                  HMASTLOCK;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [DATA_WIDTH-1:0] HWDATA;

    modport slave (
        input  HBUSREQ0, HBUSREQ1, HLOCK0, HLOCK1,
        input  HADDR0, HADDR1, HTRANS0, HTRANS1, HWRITE0, HWRITE1,
        input  HSIZE0, HSIZE1, HBURST0, HBURST1, HPROT0, HPROT1,
        input  HWDATA0, HWDATA1, HREADY,
        output HGRANT0, HGRANT1, HMASTER, HMASTLOCK,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
    );

    modport master (
        output HBUSREQ0, HBUSREQ1, HLOCK0, HLOCK1,
        output HADDR0, HADDR1, HTRANS0, HTRANS1, HWRITE0, HWRITE1,
        output HSIZE0, HSIZE1, HBURST0, HBURST1, HPROT0, HPROT1,
        output HWDATA0, HWDATA1, HREADY,
        input  HGRANT0, HGRANT1, HMASTER, HMASTLOCK,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// rtl/ahb_bus_arbiter.sv - two-master round-robin AHB-Lite arbiter and bus mux
module ahb_bus_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic              HCLK,
    input  logic              rst,
    ahb_bus_arbiter_if.slave  bus
);
    localparam logic       DFLT      = (DEFAULT_MASTER != 0);
    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_BUSY   = 2'd1;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;

    logic       grant_q, grant_d;
    logic       owner_q, owner_d;
    logic       data_q, data_d;
    logic       last_q, last_d;
    logic       lock_q, lock_d;
    logic [3:0] beats_rem_q, beats_rem_d;

    logic       [1:0]            own_trans;
    logic       [2:0]            own_burst;
    logic                        fixed_burst;
    logic                        gnt_lock;
    logic                        gnt_req;
    logic                        arb_point;
    logic       [3:0]            burst_len_m1;
    logic       [ADDR_WIDTH-1:0] haddr_mux;
    logic       [DATA_WIDTH-1:0] hwdata_mux;

    always_comb begin
        own_trans   = owner_q ? bus.HTRANS1 : bus.HTRANS0;
        own_burst   = owner_q ? bus.HBURST1 : bus.HBURST0;
        fixed_burst = (own_burst > 3'd1);
        gnt_lock    = grant_q ? bus.HLOCK1   : bus.HLOCK0;
        gnt_req     = grant_q ? bus.HBUSREQ1 : bus.HBUSREQ0;

        // Fixed-length bursts only yield on their final beat; INCR may yield anywhere.
        arb_point = bus.HREADY
                  && (own_trans != TR_BUSY)
                  && !((own_trans == TR_NONSEQ) && fixed_burst)
                  && (beats_rem_q <= 4'd1)
                  && !(gnt_lock && gnt_req);

        case (own_burst)
            3'd2, 3'd3: burst_len_m1 = 4'd3;
            3'd4, 3'd5: burst_len_m1 = 4'd7;
            3'd6, 3'd7: burst_len_m1 = 4'd15;
            default:    burst_len_m1 = 4'd0;
        endcase
    end

    always_comb begin
        grant_d     = grant_q;
        owner_d     = owner_q;
        data_d      = data_q;
        last_d      = last_q;
        lock_d      = lock_q;
        beats_rem_d = beats_rem_q;

        if (bus.HREADY) begin
            owner_d = grant_q;
            data_d  = owner_q;
            lock_d  = gnt_lock;
            case (own_trans)
                TR_IDLE:   beats_rem_d = 4'd0;
                TR_NONSEQ: beats_rem_d = burst_len_m1;
                TR_SEQ:    if (beats_rem_q != 4'd0) beats_rem_d = beats_rem_q - 4'd1;
                default:   beats_rem_d = beats_rem_q;
            endcase
        end

        if (arb_point) begin
            case ({bus.HBUSREQ1, bus.HBUSREQ0})
                2'b11: begin
                    grant_d = ~last_q;
                    last_d  = ~last_q;
                end
                2'b01:   grant_d = 1'b0;
                2'b10:   grant_d = 1'b1;
                default: grant_d = DFLT;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (rst) begin
            grant_q     <= DFLT;
            owner_q     <= DFLT;
            data_q      <= DFLT;
            last_q      <= DFLT;
            lock_q      <= 1'b0;
            beats_rem_q <= 4'd0;
        end else begin
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            data_q      <= data_d;
            last_q      <= last_d;
            lock_q      <= lock_d;
            beats_rem_q <= beats_rem_d;
        end
    end

    // Address/control follow the address-phase owner; write data lags by one accepted phase.
    assign haddr_mux  = owner_q ? bus.HADDR1  : bus.HADDR0;
    assign hwdata_mux = data_q  ? bus.HWDATA1 : bus.HWDATA0;

    assign bus.HGRANT0   = ~grant_q;
    assign bus.HGRANT1   = grant_q;
    assign bus.HMASTER   = owner_q;
    assign bus.HMASTLOCK = lock_q;
    assign bus.HADDR     = haddr_mux;
    assign bus.HTRANS    = own_trans;
    assign bus.HWRITE    = owner_q ? bus.HWRITE1 : bus.HWRITE0;
    assign bus.HSIZE     = owner_q ? bus.HSIZE1  : bus.HSIZE0;
    assign bus.HBURST    = own_burst;
    assign bus.HPROT     = owner_q ? bus.HPROT1  : bus.HPROT0;
    assign bus.HWDATA    = hwdata_mux;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb/tb_ahb_bus_arbiter.sv - directed self-checking bench for ahb_bus_arbiter
module tb_ahb_bus_arbiter;
    logic HCLK = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    localparam logic [31:0] A0 = 32'hA000_0000;
    localparam logic [31:0] A1 = 32'hB000_0004;
    localparam logic [31:0] D0 = 32'hD0D0_0000;
    localparam logic [31:0] D1 = 32'hD1D1_1111;

    ahb_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    ahb_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEFAULT_MASTER(0)) dut (
        .HCLK (HCLK),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    initial begin
        rst          = 1'b1;
        bus.HBUSREQ0 = 1'b0;  bus.HBUSREQ1 = 1'b0;
        bus.HLOCK0   = 1'b0;  bus.HLOCK1   = 1'b0;
        bus.HADDR0   = A0;    bus.HADDR1   = A1;
        bus.HTRANS0  = 2'd0;  bus.HTRANS1  = 2'd0;
        bus.HWRITE0  = 1'b0;  bus.HWRITE1  = 1'b1;
        bus.HSIZE0   = 3'd2;  bus.HSIZE1   = 3'd2;
        bus.HBURST0  = 3'd0;  bus.HBURST1  = 3'd0;
        bus.HPROT0   = 4'h3;  bus.HPROT1   = 4'hA;
        bus.HWDATA0  = D0;    bus.HWDATA1  = D1;
        bus.HREADY   = 1'b1;

        // Reset state
        tick(); tick();
        check("rst_gnt0", bus.HGRANT0, 1);
        check("rst_gnt1", bus.HGRANT1, 0);
        check("rst_hmaster", bus.HMASTER, 0);
        check("rst_mastlock", bus.HMASTLOCK, 0);
        check("rst_haddr", bus.HADDR, A0);
        check("rst_beats", dut.beats_rem_q, 0);
        rst = 1'b0;

        // Master 1 requests while owner 0 idles
        bus.HBUSREQ1 = 1'b1;
        tick();
        check("req1_gnt1", bus.HGRANT1, 1);
        check("req1_hmaster_old", bus.HMASTER, 0);
        tick();
        check("req1_hmaster", bus.HMASTER, 1);
        check("req1_haddr", bus.HADDR, A1);
        check("req1_hwrite", bus.HWRITE, 1);
        check("req1_hwdata_old", bus.HWDATA, D0);
        tick();
        check("req1_hwdata", bus.HWDATA, D1);

        // Both request, SINGLE transfers: round-robin toggles at each point
        bus.HBUSREQ0 = 1'b1;
        bus.HTRANS0  = 2'd2;  bus.HTRANS1 = 2'd2;
        tick();
        check("rr1_gnt1", bus.HGRANT1, 1);
        tick();
        check("rr2_gnt0", bus.HGRANT0, 1);
        check("rr2_hmaster", bus.HMASTER, 1);
        tick();
        check("rr3_gnt1", bus.HGRANT1, 1);
        check("rr3_hmaster", bus.HMASTER, 0);
        tick();
        check("rr4_gnt0", bus.HGRANT0, 1);

        // Master 0 INCR4 with a wait state on beat 2, master 1 requesting
        bus.HBUSREQ1 = 1'b0;
        bus.HTRANS0  = 2'd0;  bus.HTRANS1 = 2'd0;
        tick();
        check("b4_own0", bus.HMASTER, 0);
        check("b4_gnt0", bus.HGRANT0, 1);
        bus.HBUSREQ1 = 1'b1;
        bus.HTRANS0  = 2'd2;  bus.HBURST0 = 3'd3;
        tick();
        check("b4_ns_beats", dut.beats_rem_q, 3);
        check("b4_ns_gnt0", bus.HGRANT0, 1);
        bus.HTRANS0 = 2'd3;
        tick();
        check("b4_s1_beats", dut.beats_rem_q, 2);
        bus.HREADY = 1'b0;
        tick();
        check("b4_wait_gnt0", bus.HGRANT0, 1);
        check("b4_wait_beats", dut.beats_rem_q, 2);
        bus.HREADY = 1'b1;
        tick();
        check("b4_s2_beats", dut.beats_rem_q, 1);
        check("b4_s2_gnt1", bus.HGRANT1, 0);
        check("b4_s2_hmaster", bus.HMASTER, 0);
        tick();
        check("b4_s3_gnt1", bus.HGRANT1, 1);
        check("b4_s3_hmaster", bus.HMASTER, 0);
        check("b4_s3_beats", dut.beats_rem_q, 0);
        bus.HTRANS0 = 2'd0;  bus.HBURST0 = 3'd0;  bus.HBUSREQ0 = 1'b0;
        tick();
        check("b4_hand_hmaster", bus.HMASTER, 1);
        check("b4_hand_gnt1", bus.HGRANT1, 1);

        // Master 1 locked pair of SINGLE transfers, master 0 contending
        bus.HLOCK1 = 1'b1;  bus.HBUSREQ0 = 1'b1;  bus.HTRANS1 = 2'd0;
        tick();
        check("lk1_mastlock", bus.HMASTLOCK, 1);
        check("lk1_gnt1", bus.HGRANT1, 1);
        bus.HTRANS1 = 2'd2;
        tick();
        check("lk2_mastlock", bus.HMASTLOCK, 1);
        check("lk2_gnt1", bus.HGRANT1, 1);
        bus.HLOCK1 = 1'b0;
        tick();
        check("lk_rel_gnt0", bus.HGRANT0, 1);
        check("lk_rel_mastlock", bus.HMASTLOCK, 0);
        check("lk_rel_hmaster", bus.HMASTER, 1);

        // Reset mid INCR8 from master 1
        bus.HBUSREQ0 = 1'b0;  bus.HTRANS1 = 2'd0;
        tick();
        check("r8_gnt1", bus.HGRANT1, 1);
        check("r8_hmaster_old", bus.HMASTER, 0);
        tick();
        check("r8_hmaster", bus.HMASTER, 1);
        bus.HTRANS1 = 2'd2;  bus.HBURST1 = 3'd5;
        tick();
        check("r8_ns_beats", dut.beats_rem_q, 7);
        bus.HTRANS1 = 2'd3;
        tick();
        check("r8_s1_beats", dut.beats_rem_q, 6);
        rst = 1'b1;
        tick();
        check("r8_rst_gnt0", bus.HGRANT0, 1);
        check("r8_rst_gnt1", bus.HGRANT1, 0);
        check("r8_rst_hmaster", bus.HMASTER, 0);
        check("r8_rst_beats", dut.beats_rem_q, 0);
        check("r8_rst_mastlock", bus.HMASTLOCK, 0);
        check("r8_rst_haddr", bus.HADDR, A0);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
